// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: funct3 encodings, sign classes, reuse-buffer state.
package mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {SC_ANY, SC_SS, SC_SU, SC_UU} mul_sign_t;

  typedef enum logic {BUF_EMPTY, BUF_VALID} buf_state_t;

  // Operand signedness a multiply depends on; low-half results do not care.
  function automatic mul_sign_t sign_class(input logic [2:0] funct3, input logic w64);
    mul_sign_t c;
    c = SC_ANY;
    if (!w64) begin
      case (funct3)
        F3_MULH:   c = SC_SS;
        F3_MULHSU: c = SC_SU;
        F3_MULHU:  c = SC_UU;
        default:   c = SC_ANY;
      endcase
    end
    return c;
  endfunction

  // Low-half writers produce the unsigned product, so the entry is tagged UU.
  function automatic mul_sign_t stored_class(input mul_sign_t c);
    return (c == SC_ANY) ? SC_UU : c;
  endfunction

endpackage

// File: rtl/mul_reuse_buf.sv
// One-entry product reuse buffer with E-stage comparator (buffer or pending M-stage write).
module mul_reuse_buf
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_e,
  input  mul_sign_t         class_e,
  input  logic [XLEN-1:0]   src_a_e,
  input  logic [XLEN-1:0]   src_b_e,
  input  logic              wr_en,
  input  logic [XLEN-1:0]   wr_a,
  input  logic [XLEN-1:0]   wr_b,
  input  mul_sign_t         wr_class,
  input  logic [2*XLEN-1:0] wr_prod,
  output logic              hit_e_c,
  output logic [2*XLEN-1:0] buf_prod
);

  localparam int unsigned PW = 2 * XLEN;

  buf_state_t      state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  mul_sign_t       class_q, class_d;
  logic [PW-1:0]   prod_q, prod_d;

  logic [XLEN-1:0] ent_a, ent_b;
  mul_sign_t       ent_class;
  logic            ent_ok;

  // Entry update: a write only ever fills or replaces; flushes never invalidate.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    class_d = class_q;
    prod_d  = prod_q;
    if (wr_en) begin
      state_d = BUF_VALID;
      a_d     = wr_a;
      b_d     = wr_b;
      class_d = wr_class;
      prod_d  = wr_prod;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BUF_EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      class_q <= SC_ANY;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      class_q <= class_d;
      prod_q  <= prod_d;
    end
  end

  // Compare against whatever the buffer will hold once this E op reaches M.
  always_comb begin
    ent_a     = a_q;
    ent_b     = b_q;
    ent_class = class_q;
    ent_ok    = (state_q == BUF_VALID);
    if (wr_en) begin
      ent_a     = wr_a;
      ent_b     = wr_b;
      ent_class = wr_class;
      ent_ok    = 1'b1;
    end
    hit_e_c = valid_e & ent_ok & (src_a_e == ent_a) & (src_b_e == ent_b) &
              ((class_e == SC_ANY) | (class_e == ent_class));
  end

  assign buf_prod = prod_q;

endmodule

// File: rtl/mul_result_stage.sv
// Multiplier result stage: E->M->W pipeline regs, reuse-buffer mux, result select/sign-extend.
module mul_result_stage
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter bit          REUSE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallM,
  input  logic              FlushM,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              MulValidE,
  input  logic [2:0]        Funct3E,
  input  logic              W64E,
  input  logic [XLEN-1:0]   ForwardedSrcAE,
  input  logic [XLEN-1:0]   ForwardedSrcBE,
  input  logic [2*XLEN-1:0] ProdM,
  output logic              ReuseHitE,
  output logic [XLEN-1:0]   MulResultW
);

  localparam int unsigned PW       = 2 * XLEN;
  localparam bit          HAS_WORD = (XLEN > 32);

  logic            w64_e;
  mul_sign_t       class_e;
  logic            hit_e;

  logic            mul_valid_m_q, mul_valid_m_d;
  logic [2:0]      funct3_m_q, funct3_m_d;
  logic            w64_m_q, w64_m_d;
  logic            hit_m_q, hit_m_d;
  logic [XLEN-1:0] src_a_m_q, src_a_m_d, src_b_m_q, src_b_m_d;

  mul_sign_t       class_m;
  logic            wr_en;
  logic [PW-1:0]   buf_prod, prod_sel;
  logic [XLEN-1:0] word_ext, result_m;
  logic [XLEN-1:0] result_w_q, result_w_d;

  assign w64_e   = HAS_WORD ? W64E : 1'b0;
  assign class_e = sign_class(Funct3E, w64_e);
  assign class_m = sign_class(funct3_m_q, w64_m_q);
  assign wr_en   = mul_valid_m_q & ~hit_m_q & ~StallM & ~FlushW;

  if (REUSE_EN) begin : g_reuse
    mul_reuse_buf #(.XLEN(XLEN)) u_buf (
      .clk      (clk),
      .reset    (reset),
      .valid_e  (MulValidE),
      .class_e  (class_e),
      .src_a_e  (ForwardedSrcAE),
      .src_b_e  (ForwardedSrcBE),
      .wr_en    (wr_en),
      .wr_a     (src_a_m_q),
      .wr_b     (src_b_m_q),
      .wr_class (stored_class(class_m)),
      .wr_prod  (ProdM),
      .hit_e_c  (hit_e),
      .buf_prod (buf_prod)
    );
  end else begin : g_no_reuse
    assign hit_e    = 1'b0;
    assign buf_prod = '0;
  end

  assign ReuseHitE = hit_e;

  // E->M register: clear beats stall.
  always_comb begin
    mul_valid_m_d = mul_valid_m_q;
    funct3_m_d    = funct3_m_q;
    w64_m_d       = w64_m_q;
    hit_m_d       = hit_m_q;
    src_a_m_d     = src_a_m_q;
    src_b_m_d     = src_b_m_q;
    if (FlushM) begin
      mul_valid_m_d = 1'b0;
      funct3_m_d    = 3'b000;
      w64_m_d       = 1'b0;
      hit_m_d       = 1'b0;
      src_a_m_d     = '0;
      src_b_m_d     = '0;
    end else if (!StallM) begin
      mul_valid_m_d = MulValidE;
      funct3_m_d    = Funct3E;
      w64_m_d       = w64_e;
      hit_m_d       = hit_e;
      src_a_m_d     = ForwardedSrcAE;
      src_b_m_d     = ForwardedSrcBE;
    end
  end

  // E->M state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_valid_m_q <= 1'b0;
      funct3_m_q    <= 3'b000;
      w64_m_q       <= 1'b0;
      hit_m_q       <= 1'b0;
      src_a_m_q     <= '0;
      src_b_m_q     <= '0;
    end else begin
      mul_valid_m_q <= mul_valid_m_d;
      funct3_m_q    <= funct3_m_d;
      w64_m_q       <= w64_m_d;
      hit_m_q       <= hit_m_d;
      src_a_m_q     <= src_a_m_d;
      src_b_m_q     <= src_b_m_d;
    end
  end

  assign prod_sel = hit_m_q ? buf_prod : ProdM;

  if (HAS_WORD) begin : g_word
    assign word_ext = {{(XLEN-32){prod_sel[31]}}, prod_sel[31:0]};
  end else begin : g_no_word
    assign word_ext = prod_sel[XLEN-1:0];
  end

  // Result select: low half for MUL, high half for MULH*, sign-extended word for MULW.
  always_comb begin
    result_m = '0;
    if (mul_valid_m_q) begin
      if (w64_m_q)                    result_m = word_ext;
      else if (funct3_m_q == F3_MUL)  result_m = prod_sel[XLEN-1:0];
      else                            result_m = prod_sel[PW-1:XLEN];
    end
  end

  // M->W register: clear beats stall.
  always_comb begin
    result_w_d = result_w_q;
    if (FlushW)       result_w_d = '0;
    else if (!StallW) result_w_d = result_m;
  end

  // W-stage result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) result_w_q <= '0;
    else        result_w_q <= result_w_d;
  end

  assign MulResultW = result_w_q;

endmodule

// File: tb/tb_mul_result_stage.sv
// Bench for mul_result_stage: arithmetic reference model plus directed and random stimulus.
module tb_mul_result_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         StallM, FlushM, StallW, FlushW;
  logic         MulValidE;
  logic [2:0]   Funct3E;
  logic         W64E;
  logic [63:0]  SrcA, SrcB;
  logic [127:0] ProdM;
  logic         ReuseHitE;
  logic [63:0]  MulResultW;

  logic         n_valid;
  logic [2:0]   n_f3;
  logic [31:0]  n_a, n_b;
  logic [63:0]  n_prod;
  logic         n_hit;
  logic [31:0]  n_res;

  always #5 clk = ~clk;

  mul_result_stage #(.XLEN(64), .REUSE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM), .StallW(StallW), .FlushW(FlushW),
    .MulValidE(MulValidE), .Funct3E(Funct3E), .W64E(W64E), .ForwardedSrcAE(SrcA),
    .ForwardedSrcBE(SrcB), .ProdM(ProdM), .ReuseHitE(ReuseHitE), .MulResultW(MulResultW)
  );

  mul_result_stage #(.XLEN(32), .REUSE_EN(1'b0)) dut_n (
    .clk(clk), .reset(reset), .StallM(1'b0), .FlushM(1'b0), .StallW(1'b0), .FlushW(1'b0),
    .MulValidE(n_valid), .Funct3E(n_f3), .W64E(1'b0), .ForwardedSrcAE(n_a),
    .ForwardedSrcBE(n_b), .ProdM(n_prod), .ReuseHitE(n_hit), .MulResultW(n_res)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit run      = 1'b0;

  localparam logic [127:0] GARBAGE = 128'h5A5A_1234_DEAD_BEEF_0BAD_F00D_C0DE_7777;

  // Reference model state: instruction in M, last committed product entry, W expectation.
  bit          m_v, m_hit, m_w;
  logic [2:0]  m_f3;
  logic [63:0] m_a, m_b;
  bit          ent_v;
  logic [63:0] ent_a, ent_b;
  int          ent_cls;
  bit          w_chk;
  logic [63:0] w_res;

  // 0 = any, 1 = signed*signed, 2 = signed*unsigned, 3 = unsigned*unsigned
  function automatic int cls_of(input logic [2:0] f3, input bit w);
    if (w) return 0;
    case (f3)
      3'd1:    return 1;
      3'd2:    return 2;
      3'd3:    return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int st_cls(input int c);
    return (c == 0) ? 3 : c;
  endfunction

  function automatic logic [127:0] full_prod(input logic [63:0] a, input logic [63:0] b, input int c);
    logic [127:0] ea, eb;
    ea = (c == 1 || c == 2) ? {{64{a[63]}}, a} : {64'b0, a};
    eb = (c == 1) ? {{64{b[63]}}, b} : {64'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                             input logic [2:0] f3, input bit w);
    logic [127:0] p;
    p = full_prod(a, b, cls_of(f3, w));
    if (w) return {{32{p[31]}}, p[31:0]};
    if (f3 == 3'd0) return p[63:0];
    return p[127:64];
  endfunction

  function automatic bit m_commits();
    return m_v && !m_hit && !StallM && !FlushW;
  endfunction

  // A multiply hits when it matches the product that will be stored once it reaches M.
  function automatic bit exp_hit();
    int ce;
    if (!MulValidE) return 1'b0;
    ce = cls_of(Funct3E, W64E);
    if (m_commits())
      return (SrcA == m_a) && (SrcB == m_b) && (ce == 0 || ce == st_cls(cls_of(m_f3, m_w)));
    if (!ent_v) return 1'b0;
    return (SrcA == ent_a) && (SrcB == ent_b) && (ce == 0 || ce == ent_cls);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Model advance on each clock edge, cleared asynchronously by reset.
  always @(posedge clk or negedge reset) begin : model
    bit h;
    if (!reset) begin
      m_v   <= 1'b0;
      m_hit <= 1'b0;
      ent_v <= 1'b0;
      w_chk <= 1'b1;
      w_res <= '0;
    end else begin
      h = exp_hit();
      if (FlushW) begin
        w_chk <= 1'b1;
        w_res <= '0;
      end else if (!StallW) begin
        w_chk <= m_v;
        w_res <= ref_result(m_a, m_b, m_f3, m_w);
      end
      if (m_commits()) begin
        ent_v   <= 1'b1;
        ent_a   <= m_a;
        ent_b   <= m_b;
        ent_cls <= st_cls(cls_of(m_f3, m_w));
      end
      if (FlushM) begin
        m_v   <= 1'b0;
        m_hit <= 1'b0;
      end else if (!StallM) begin
        m_v   <= MulValidE;
        m_hit <= h;
        m_a   <= SrcA;
        m_b   <= SrcB;
        m_f3  <= Funct3E;
        m_w   <= W64E;
      end
    end
  end

  // Multiplier stand-in: true product, or garbage when the buffer is expected to supply it.
  always_comb begin
    if (m_v && m_hit) ProdM = GARBAGE;
    else              ProdM = full_prod(m_a, m_b, st_cls(cls_of(m_f3, m_w)));
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (run) begin
      check("reuse_hit_e", 128'(ReuseHitE), 128'(exp_hit()));
      if (w_chk) check("mul_result_w", 128'(MulResultW), 128'(w_res));
    end
  end

  task automatic issue(input bit v, input logic [2:0] f3, input bit w,
                       input logic [63:0] a, input logic [63:0] b);
    MulValidE = v;
    Funct3E   = f3;
    W64E      = w;
    SrcA      = a;
    SrcB      = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic [63:0] pool [4];

  initial begin
    reset = 1'b0;
    StallM = 1'b0; FlushM = 1'b0; StallW = 1'b0; FlushW = 1'b0;
    issue(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    n_valid = 1'b0; n_f3 = 3'd0; n_a = 32'd0; n_b = 32'd0; n_prod = 64'd0;
    repeat (2) tick();
    @(negedge clk); #1;
    reset = 1'b1;
    run   = 1'b1;

    // Reset in the middle of a MULH.
    issue(1'b1, 3'd1, 1'b0, M1, 64'd2);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("rst_hit", 128'(ReuseHitE), 128'd0);
    check("rst_result", 128'(MulResultW), 128'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("post_rst_hit", 128'(ReuseHitE), 128'd0);
    tick();

    // MULH then MUL on the same operands, back to back.
    issue(1'b1, 3'd0, 1'b0, 64'd3, 64'd5);
    tick();
    issue(1'b1, 3'd1, 1'b0, M1, 64'd2);
    tick();
    issue(1'b1, 3'd0, 1'b0, M1, 64'd2);
    #1;
    check("b2b_mul_hit", 128'(ReuseHitE), 128'd1);
    tick();
    check("mulh_result", 128'(MulResultW), 128'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    tick();
    check("mul_reuse_result", 128'(MulResultW), 128'hFFFF_FFFF_FFFF_FFFE);

    // MULH then MULHU: different class, no reuse.
    issue(1'b1, 3'd1, 1'b0, M1, 64'd2);
    tick();
    issue(1'b1, 3'd3, 1'b0, M1, 64'd2);
    #1;
    check("mulhu_class_miss", 128'(ReuseHitE), 128'd0);
    tick();
    issue(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    tick();
    check("mulhu_result", 128'(MulResultW), 128'h0000_0000_0000_0001);

    // MULW and its repeat.
    issue(1'b1, 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2);
    #1;
    check("mulw_first_hit", 128'(ReuseHitE), 128'd0);
    tick();
    #1;
    check("mulw_repeat_hit", 128'(ReuseHitE), 128'd1);
    tick();
    check("mulw_result", 128'(MulResultW), 128'hFFFF_FFFF_FFFF_FFFE);
    issue(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    tick();
    check("mulw_reuse_result", 128'(MulResultW), 128'hFFFF_FFFF_FFFF_FFFE);

    // W stall holds the result; W flush blocks the buffer write.
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stallw_hold", 128'(MulResultW), 128'hFFFF_FFFF_FFFF_FFFE);
    end
    StallW = 1'b0;
    issue(1'b1, 3'd1, 1'b0, 64'd9, 64'd11);
    tick();
    FlushW = 1'b1;
    issue(1'b1, 3'd0, 1'b0, 64'd9, 64'd11);
    #1;
    check("flushw_no_pending_hit", 128'(ReuseHitE), 128'd0);
    tick();
    FlushW = 1'b0;
    check("flushw_result", 128'(MulResultW), 128'd0);
    issue(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    repeat (2) tick();

    // Randomized traffic over a small operand pool so reuse happens often.
    pool[0] = M1;
    pool[1] = 64'd2;
    pool[2] = 64'h7FFF_FFFF;
    pool[3] = 64'h8000_0000_0000_0001;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 49) pool[3] = {$urandom, $urandom};
      MulValidE = ($urandom_range(9) < 7);
      Funct3E   = 3'($urandom_range(3));
      W64E      = (Funct3E == 3'd0) && ($urandom_range(3) == 0);
      SrcA      = pool[$urandom_range(3)];
      SrcB      = pool[$urandom_range(3)];
      StallM    = ($urandom_range(9) == 0);
      FlushM    = ($urandom_range(9) == 0);
      StallW    = ($urandom_range(9) == 0);
      FlushW    = ($urandom_range(9) == 0);
      tick();
    end
    StallM = 1'b0; FlushM = 1'b0; StallW = 1'b0; FlushW = 1'b0;
    issue(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    repeat (3) tick();

    // XLEN=32 instance with reuse removed: repeated MULHU never hits.
    n_valid = 1'b1;
    n_f3    = 3'd3;
    n_a     = 32'hFFFF_FFFF;
    n_b     = 32'hFFFF_FFFF;
    n_prod  = 64'(n_a) * 64'(n_b);
    #1;
    check("n_hit_first", 128'(n_hit), 128'd0);
    tick();
    #1;
    check("n_hit_repeat", 128'(n_hit), 128'd0);
    tick();
    check("n_mulhu_result", 128'(n_res), 128'hFFFF_FFFE);
    n_valid = 1'b0;
    tick();
    check("n_mulhu_result2", 128'(n_res), 128'hFFFF_FFFE);
    check("n_hit_idle", 128'(n_hit), 128'd0);

    run = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
